mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Iterative RV32M multiply/divide unit. It sits beside the ALU on the execute stage and takes the same operand buses, bus_a (rs1) and bus_b (rs2).
- Its result feeds the writeback mux as an alternative to alu_out.
- busy stalls PC and register-file write until done.
- Multi-cycle: one radix-2 step per clock.

Parameters:
- WIDTH, 32, operand and result width.
- OP_SEL, 3, width of op select (funct3 encoding).

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  synchronous active-low reset
- start  input  1  request; accepted only in IDLE
- abort  input  1  cancel the in-flight operation (pipeline flush)
- op  input  OP_SEL  MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
- bus_a  input  WIDTH  rs1 operand, signed view
- bus_b  input  WIDTH  rs2 operand, signed view
- busy  output  1  high while an operation is in flight (stall request)
- done  output  1  one-cycle pulse when result becomes valid
- result  output  WIDTH  result, held until the next accepted start

Behaviour:
- Reset: when rstn=0 at a clock edge, the unit goes to state IDLE, with busy=0, done=0, result=0 and all internal registers cleared. Reset mid-operation discards the operation and produces no done.
- States and transitions:
  - IDLE to CALC when start=1.
  - CALC to FIX after WIDTH iterations.
  - FIX to DONE unconditionally.
  - DONE to IDLE unconditionally.
  - DONE to CALC directly if start=1 in DONE (back-to-back).
- Accept edge k (start=1 in IDLE or DONE):
  - Latch op.
  - Latch |a| and |b|. Sign treatment by op:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: only a signed.
    - Others: both operands unsigned.
  - Latch the result sign: sign_a^sign_b for the quotient/product; sign_a for the remainder.
  - Clear the step counter.
- CALC, one step per cycle:
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring; shift remainder:quotient left one bit, subtract the divisor, keep the difference if non-negative and set the quotient bit.
  - The counter runs 0..WIDTH-1.
- FIX:
  - Apply two's-complement negation per the latched sign.
  - Select the output:
    - MUL: low WIDTH bits.
    - MULH*: high WIDTH bits.
    - DIV*: quotient.
    - REM*: remainder.
  - Register the result.
- DONE: done=1 for exactly one cycle; busy=0 in DONE.
- Timing: busy=1 from edge k+1 through the FIX cycle. done=1 in the cycle after edge k+WIDTH+2, i.e. fixed latency WIDTH+2 cycles.
- Special cases, which are RISC-V mandated and bit-exact:
  - Divide by zero: DIV and DIVU give all ones; REM and REMU give bus_a.
  - Signed overflow (a=0x80000000, b=-1): DIV gives 0x80000000; REM gives 0.
  - These are detected at accept and force the FIX output, overriding the datapath.
- start while busy is ignored: no re-latch, no error.
- op and operands must be stable only at the accept edge.
- abort: top priority after reset. In any state, the next state is IDLE, busy drops the following cycle, no done pulse occurs, and result keeps its previous value.
- Simultaneous abort and start in IDLE: abort wins; the request is not accepted.
- result changes only in FIX and on reset.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- With the macro defined: divide-by-zero and signed-overflow cases skip CALC and go IDLE to FIX directly, so done arrives after 2 cycles. MUL* with either operand zero also takes this path with result 0.
- Without the macro: every operation takes exactly WIDTH+2 cycles. Special-case values are still forced in FIX.
- Results are identical either way; only the latency differs.

Decomposition:
- Shared control package holds:
  - MDU op encodings (MDU_MUL..MDU_REMU), defined alongside the existing ALU select constants.
  - The state enum typedef (IDLE, CALC, FIX, DONE).
  - The writeback-mux select value for the MDU result.
- One sub-module, mdu_sign_fix: combinational operand absolute-value and sign-extract, reused for the output negation.
- The datapath and FSM stay in mdu_iterative.

Test Plan:
1. MUL a=7, b=-3 -> done at start+34 cycles, result=0xFFFFFFEB; busy high for 33 cycles.
2. MULH a=0x80000000, b=0x80000000 -> result=0x40000000. MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV a=-20, b=3 -> 0xFFFFFFFA (-6). REM a=-20, b=3 -> 0xFFFFFFFE (-2). DIVU a=100, b=7 -> 14. REMU -> 2.
4. DIV a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0. With MDU_EARLY_OUT_EN, done arrives at start+2.
5. Start DIVU, assert abort at cycle 10 -> busy=0 next cycle, no done, result unchanged. Second start during busy is ignored, confirmed by the original result and timing.
6. rstn=0 mid-CALC -> next cycle busy=0, done=0, result=0. Back-to-back start during DONE -> second op accepted, done again after WIDTH+2 cycles.

Source files
------------

// File: rtl/mdu_iterative_pkg.sv
// mdu_iterative_pkg: shared execute-stage encodings for ALU select, MDU ops, MDU FSM and writeback mux
package mdu_iterative_pkg;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;
    localparam logic [2:0] MDU_MUL = 3'd0, MDU_MULH = 3'd1, MDU_MULHSU = 3'd2, MDU_MULHU = 3'd3,
                           MDU_DIV = 3'd4, MDU_DIVU = 3'd5, MDU_REM = 3'd6, MDU_REMU = 3'd7;
    localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_MDU = 2'd3;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} mdu_state_e;
endpackage

// File: rtl/mdu_iterative_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negation, used for operand magnitudes and signed results
module mdu_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic         neg,
    output logic [N-1:0] y
);
    assign y = neg ? -x : x;
endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative RV32M multiply/divide unit; MDU_EARLY_OUT_EN lets trivial cases skip CALC
module mdu_iterative
    import mdu_iterative_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int OP_SEL = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [OP_SEL-1:0] op,
    input  logic [WIDTH-1:0]  bus_a,
    input  logic [WIDTH-1:0]  bus_b,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result
);
    localparam int CW = $clog2(WIDTH);
    mdu_state_e state, state_n;
    logic [OP_SEL-1:0] op_q;
    logic [WIDTH-1:0] m_q, spec_val_q, spec_val, abs_a, abs_b;
    logic [2*WIDTH-1:0] acc_q, acc_n, pre_fix, fix_out;
    logic [CW-1:0] cnt_q;
    logic [WIDTH:0] sum, shifted, diff;
    logic neg_q, spec_q, spec, early, sign_a, sign_b, is_div, accept, dz, ovf, mz;
    assign is_div = op[2];
    assign sign_a = bus_a[WIDTH-1] && (op == MDU_MULH || op == MDU_MULHSU || op == MDU_DIV || op == MDU_REM);
    assign sign_b = bus_b[WIDTH-1] && (op == MDU_MULH || op == MDU_DIV || op == MDU_REM);
    mdu_sign_fix #(.N(WIDTH)) u_abs_a (.x(bus_a), .neg(sign_a), .y(abs_a));
    mdu_sign_fix #(.N(WIDTH)) u_abs_b (.x(bus_b), .neg(sign_b), .y(abs_b));
    assign dz = is_div && bus_b == '0;
    assign ovf = (op == MDU_DIV || op == MDU_REM) && bus_a == {1'b1, {(WIDTH-1){1'b0}}} && &bus_b;
    assign mz = !is_div && (bus_a == '0 || bus_b == '0);
    assign spec = dz || ovf || mz;
    // Overflowing DIV returns the dividend itself, which is exactly the most negative value
    assign spec_val = dz ? (op[1] ? bus_a : '1) : (ovf && !op[1]) ? bus_a : '0;
`ifdef MDU_EARLY_OUT_EN
    assign early = spec;
`else
    assign early = 1'b0;
`endif
    assign accept = start && !abort && (state == IDLE || state == DONE);
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign shifted = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff = shifted - {1'b0, m_q};
    assign acc_n = op_q[2] ? (diff[WIDTH] ? {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                          : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
                           : {sum, acc_q[WIDTH-1:1]};
    // Negation runs over the full double-width product so MULH* high halves come out right
    assign pre_fix = op_q[2] ? {{WIDTH{1'b0}}, op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0]} : acc_q;
    mdu_sign_fix #(.N(2*WIDTH)) u_fix (.x(pre_fix), .neg(neg_q), .y(fix_out));
    always_comb begin
        state_n = abort ? IDLE :
                  accept ? (early ? FIX : CALC) :
                  state == CALC ? (cnt_q == CW'(WIDTH-1) ? FIX : CALC) :
                  state == FIX ? DONE : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            op_q       <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            result     <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q       <= op;
                m_q        <= is_div ? abs_b : abs_a;
                acc_q      <= {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
                cnt_q      <= '0;
                neg_q      <= (is_div && op[1]) ? sign_a : sign_a ^ sign_b;
                spec_q     <= spec;
                spec_val_q <= spec_val;
            end else if (state == CALC && !abort) begin
                acc_q <= acc_n;
                cnt_q <= cnt_q + CW'(1);
            end
            if (state == FIX && !abort)
                result <= spec_q ? spec_val_q :
                          (op_q == MDU_MUL || op_q[2]) ? fix_out[WIDTH-1:0] : fix_out[2*WIDTH-1:WIDTH];
        end
    end
    assign busy = state == CALC || state == FIX;
    assign done = state == DONE;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: randomized and directed checks of mdu_iterative against an arithmetic reference model
module tb_mdu_iterative;
    logic clk = 1'b0;
    logic rstn, start, abort;
    logic [2:0] op;
    logic [31:0] bus_a, bus_b, result;
    logic busy, done;
    int errors = 0;
    int checks = 0;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    mdu_iterative #(.WIDTH(32), .OP_SEL(3)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .op(op),
        .bus_a(bus_a), .bus_b(bus_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] qa, qb, q;
        logic ov;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        qa = a;
        qb = b;
        ov = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return a;
                q = qa / qb;
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                q = qa % qb;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic trivial;
        trivial = o[2] ? (b == 0 || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                       : (a == 0 || b == 0);
        return (EARLY && trivial) ? 2 : 34;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bc, output logic [31:0] r);
        @(posedge clk); #1;
        op = o; bus_a = a; bus_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom_range(0, 7)); bus_a = $urandom; bus_b = $urandom;
        lat = 1;
        bc = 0;
        while (!done && lat < 200) begin
            if (busy) bc++;
            @(posedge clk); #1;
            lat++;
        end
        r = result;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0; op = '0; bus_a = '0; bus_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
        rstn = 1'b1;
    endtask

    typedef struct {logic [2:0] o; logic [31:0] a; logic [31:0] b; logic [31:0] r;} vec_t;

    task automatic test_directed();
        vec_t v [15] = '{
            '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
            '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA},
            '{3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE},
            '{3'd5, 32'd100, 32'd7, 32'd14},
            '{3'd7, 32'd100, 32'd7, 32'd2},
            '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF},
            '{3'd6, 32'd5, 32'd0, 32'd5},
            '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0},
            '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF},
            '{3'd7, 32'd5, 32'd0, 32'd5},
            '{3'd0, 32'd0, 32'd1234, 32'h0}
        };
        int lat, bc;
        logic [31:0] r;
        for (int i = 0; i < 15; i++) begin
            run_op(v[i].o, v[i].a, v[i].b, lat, bc, r);
            checks++; if (r !== v[i].r) begin errors++; $display("FAIL dir%0d_result got=%h want=%h", i, r, v[i].r); end
            checks++; if (lat != exp_lat(v[i].o, v[i].a, v[i].b)) begin errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, exp_lat(v[i].o, v[i].a, v[i].b)); end
            checks++; if (bc != exp_lat(v[i].o, v[i].a, v[i].b) - 1) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, bc, exp_lat(v[i].o, v[i].a, v[i].b) - 1); end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0 || result !== v[i].r) begin errors++; $display("FAIL dir%0d_hold done=%b result=%h want done=0 result=%h", i, done, result, v[i].r); end
        end
    endtask

    task automatic test_random();
        int lat, bc, sel;
        logic [2:0] o;
        logic [31:0] a, b, r;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 0;
            if (sel == 1) a = 0;
            if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 3) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
            run_op(o, a, b, lat, bc, r);
            checks++; if (r !== model(o, a, b)) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, r, model(o, a, b)); end
            checks++; if (lat != exp_lat(o, a, b)) begin errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, exp_lat(o, a, b)); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] prev;
        int seen;
        prev = result;
        @(posedge clk); #1;
        op = 3'd5; bus_a = $urandom; bus_b = $urandom | 32'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n < 10; n++) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got=%b want=1", busy); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done got=%0d pulses want=0", seen); end
        checks++; if (result !== prev) begin errors++; $display("FAIL abort_result got=%h want=%h", result, prev); end
    endtask

    task automatic test_ignore_start();
        logic [31:0] a, b;
        int lat;
        a = $urandom;
        b = $urandom_range(2, 1000);
        @(posedge clk); #1;
        op = 3'd5; bus_a = a; bus_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            start = (lat == 5);
            if (lat == 5) begin op = 3'd0; bus_a = $urandom; bus_b = $urandom; end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        checks++; if (lat != 34) begin errors++; $display("FAIL ignore_start_latency got=%0d want=34", lat); end
        checks++; if (result !== a / b) begin errors++; $display("FAIL ignore_start_result got=%h want=%h", result, a / b); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(posedge clk); #1;
        op = 3'd3; bus_a = $urandom | 32'h1; bus_b = $urandom | 32'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b want=0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result got=%h want=0", result); end
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d pulses want=0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        int lat;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom_range(1, 50000);
        @(posedge clk); #1;
        op = 3'd1; bus_a = a1; bus_b = b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != exp_lat(3'd1, a1, b1) || result !== model(3'd1, a1, b1)) begin errors++; $display("FAIL b2b_first lat=%0d result=%h want lat=%0d result=%h", lat, result, exp_lat(3'd1, a1, b1), model(3'd1, a1, b1)); end
        op = 3'd6; bus_a = a2; bus_b = b2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b want=1", busy); end
        lat = 1;
        while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 34) begin errors++; $display("FAIL b2b_second_latency got=%0d want=34", lat); end
        checks++; if (result !== model(3'd6, a2, b2)) begin errors++; $display("FAIL b2b_second_result got=%h want=%h", result, model(3'd6, a2, b2)); end
    endtask

    task automatic test_abort_start_idle();
        int seen;
        @(posedge clk); #1;
        op = 3'd5; bus_a = 32'd77; bus_b = 32'd5; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_busy got=%b want=0", busy); end
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_start_no_done got=%0d pulses want=0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_abort_start_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
